controller_3: RTL and testbench
===============================

Name: controller_3

Overview:
- Moore-style main control FSM for a 32-bit multicycle processor.
- It sequences fetch, decode, execute, memory and writeback from the 6-bit opcode in the instruction register.
- It drives every datapath mux select, write enable and the ALU operation code.
- It sits beside the datapath and has no data inputs.

Parameters:
- None. State and opcode encodings are fixed by this spec.

Ports:
- clk  input  1  Single clock; all state updates on the rising edge.
- reset  input  1  Asynchronous, active-low reset. reset=0 forces state S0 immediately.
- opcode  input  6  IR[31:26]; held stable by the datapath from S1 onward.
- PCWrite  output  1  Unconditional PC load.
- PCWriteCond  output  1  PC load qualified by ALU zero.
- DMEMWrite  output  1  Data memory write enable.
- IRWrite  output  1  Instruction register load.
- MemtoReg  output  2  Register write-data select: 00 ALUOut, 01 DMEM read data, 10 zero-extended imm16, 11 imm16<<16.
- PCSource  output  2  PC input select: 00 ALU result, 01 ALUOut register, 10 jump target {PC[31:26],IR[25:0]}.
- ALUSel  output  4  ALU operation: 0000 MOV (pass B), 0001 NOT, 0010 ADD, 0011 SUB, 0100 OR, 0101 AND, 0110 XOR, 0111 SLT.
- ALUSrcA  output  1  0 PC, 1 register A.
- ALUSrcB  output  2  00 register B, 01 constant 1, 10 sign-extended imm16, 11 zero-extended imm16.
- RegWrite  output  1  Register file write enable.
- RegReadSel  output  1  1 selects the destination field as the second read address (store data / compare operand).

Behaviour:
- The state register is 4 bits; states are numbered S0–S14. S13 is unused and goes to S0.
- During reset and in S0, every output is 0 except the S0 outputs listed below.
- Outputs are decoded from the state only, except that ALUSel in S2/S3/S4 also uses opcode. Any output not listed for a state is 0.
- Each state lasts exactly one cycle.
- Opcodes:
  - R-type 010fff: MOV/NOT/ADD/SUB/OR/AND/XOR/SLT for fff = 000..111.
  - J 000001; BEQ 100000; NOP 000000.
  - ADDI 110010, SUBI 110011, ORI 110100, ANDI 110101, XORI 110110, SLTI 110111.
  - LI 111001, LUI 111010, LWI 111011, SWI 111100.
- State outputs and transitions:
  - S0 fetch: IRWrite=1, PCWrite=1, ALUSrcA=0, ALUSrcB=01, ALUSel=ADD, PCSource=00. Goes to S1.
  - S1 decode: ALUSrcA=0, ALUSrcB=10, ALUSel=ADD (branch target into ALUOut). Next state by opcode:
    - R-type → S2.
    - ADDI/SUBI/SLTI → S3.
    - ORI/ANDI/XORI → S4.
    - LWI → S5.
    - J/BEQ/LI/LUI/SWI → S14.
    - NOP or any undefined opcode → S0.
  - S2: ALUSrcA=1, ALUSrcB=00, ALUSel={0,opcode[2:0]}. Goes to S6.
  - S3: ALUSrcA=1, ALUSrcB=10, ALUSel={0,opcode[2:0]}. Goes to S6.
  - S4: ALUSrcA=1, ALUSrcB=11, ALUSel={0,opcode[2:0]}. Goes to S6.
  - S5: ALUSrcA=1, ALUSrcB=10, ALUSel=ADD. Goes to S7.
  - S6: RegWrite=1, MemtoReg=00. Goes to S0.
  - S7: RegWrite=1, MemtoReg=01. Goes to S0.
  - S14 operand read: RegReadSel=1. Next state: J→S12, BEQ→S11, LI→S9, LUI→S10, SWI→S8, otherwise S0.
  - S8: RegReadSel=1, ALUSrcA=1, ALUSrcB=10, ALUSel=ADD, DMEMWrite=1. Goes to S0.
  - S9: RegWrite=1, MemtoReg=10. Goes to S0.
  - S10: RegWrite=1, MemtoReg=11. Goes to S0.
  - S11: RegReadSel=1, ALUSrcA=1, ALUSrcB=00, ALUSel=SUB, PCWriteCond=1, PCSource=01. Goes to S0.
  - S12: PCWrite=1, PCSource=10. Goes to S0.
- Instruction lengths: R-type and I-type ALU 4 cycles; LWI 4; J, BEQ, LI, LUI, SWI 4; NOP 2.
- Reset asserted mid-instruction aborts it; state becomes S0 asynchronously.
- After reset deasserts, the first rising edge with reset=1 leaves S0 for S1.
- Write enables (PCWrite, PCWriteCond, DMEMWrite, IRWrite, RegWrite) are never asserted together except PCWrite+IRWrite in S0.

Test Plan:
- Hold reset=0 for several cycles → state S0, IRWrite=1, PCWrite=1, ALUSrcB=01, ALUSel=0010, all other outputs 0. Release reset → S1 on the next edge.
- opcode=010011 (SUB) → states S0,S1,S2,S6. In S2: ALUSel=0011, ALUSrcA=1, ALUSrcB=00. In S6: RegWrite=1, MemtoReg=00.
- Apply each of ADDI 110010, ORI 110100, SLTI 110111 → execute states S3, S4, S3 respectively. ALUSrcB = 10, 11, 10; ALUSel = 0010, 0100, 0111.
- Apply J 000001 then BEQ 100000 → J: S0,S1,S14,S12 with PCWrite=1, PCSource=10 in S12. BEQ: S0,S1,S14,S11 with PCWriteCond=1, PCSource=01, ALUSel=0011 in S11.
- Apply LI, LUI, LWI, SWI:
  - LI: S14 then S9, MemtoReg=10, RegWrite=1.
  - LUI: S14 then S10, MemtoReg=11, RegWrite=1.
  - LWI: S5 then S7, MemtoReg=01, RegWrite=1.
  - SWI: S14 then S8, DMEMWrite=1.
- Apply NOP 000000, then opcode 111111 → each loops S0,S1,S0. Pulse reset low during S2 → outputs return to S0 values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/controller_3.sv
// Main control FSM for a 32-bit multicycle processor: sequences fetch, decode,
// execute, memory and writeback, and drives every datapath select and enable.
module controller_3 (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       DMEMWrite,
  output logic       IRWrite,
  output logic [1:0] MemtoReg,
  output logic [1:0] PCSource,
  output logic [3:0] ALUSel,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic       RegReadSel
);

  typedef enum logic [3:0] {
    S0  = 4'd0,  S1  = 4'd1,  S2  = 4'd2,  S3  = 4'd3,  S4  = 4'd4,
    S5  = 4'd5,  S6  = 4'd6,  S7  = 4'd7,  S8  = 4'd8,  S9  = 4'd9,
    S10 = 4'd10, S11 = 4'd11, S12 = 4'd12, S14 = 4'd14
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0011;

  state_t state, next_state;

  // NOTE: state registers use <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S0;
    else        state <= next_state;
  end

  // NOTE: every output gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    next_state  = S0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    DMEMWrite   = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 2'b00;
    PCSource    = 2'b00;
    ALUSel      = 4'b0000;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    RegWrite    = 1'b0;
    RegReadSel  = 1'b0;
    unique case (state)
      S0: begin
        IRWrite    = 1'b1;
        PCWrite    = 1'b1;
        ALUSrcB    = 2'b01;
        ALUSel     = ALU_ADD;
        next_state = S1;
      end
      S1: begin
        // PC + sign-extended offset is precomputed into ALUOut for BEQ.
        ALUSrcB = 2'b10;
        ALUSel  = ALU_ADD;
        casez (opcode)
          6'b010???:                      next_state = S2;
          6'b110010, 6'b110011, 6'b110111: next_state = S3;
          6'b110100, 6'b110101, 6'b110110: next_state = S4;
          6'b111011:                      next_state = S5;
          6'b000001, 6'b100000, 6'b111001,
          6'b111010, 6'b111100:           next_state = S14;
          default:                        next_state = S0;
        endcase
      end
      S2, S3, S4: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = (state == S2) ? 2'b00 : (state == S3) ? 2'b10 : 2'b11;
        ALUSel     = {1'b0, opcode[2:0]};
        next_state = S6;
      end
      S5: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUSel     = ALU_ADD;
        next_state = S7;
      end
      S6: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b00;
      end
      S7: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b01;
      end
      S14: begin
        RegReadSel = 1'b1;
        unique case (opcode)
          6'b000001: next_state = S12;
          6'b100000: next_state = S11;
          6'b111001: next_state = S9;
          6'b111010: next_state = S10;
          6'b111100: next_state = S8;
          default:   next_state = S0;
        endcase
      end
      S8: begin
        RegReadSel = 1'b1;
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUSel     = ALU_ADD;
        DMEMWrite  = 1'b1;
      end
      S9: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b10;
      end
      S10: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b11;
      end
      S11: begin
        RegReadSel  = 1'b1;
        ALUSrcA     = 1'b1;
        ALUSrcB     = 2'b00;
        ALUSel      = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S12: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      default: next_state = S0;
    endcase
  end

endmodule

// File: tb/tb_controller_3.sv
// Self-checking bench for controller_3: an instruction-level model predicts the
// output vector of every cycle; directed literals pin the model itself.
module tb_controller_3;

  logic       clk, reset;
  logic [5:0] opcode;
  logic       PCWrite, PCWriteCond, DMEMWrite, IRWrite, ALUSrcA, RegWrite, RegReadSel;
  logic [1:0] MemtoReg, PCSource, ALUSrcB;
  logic [3:0] ALUSel;

  controller_3 dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .DMEMWrite(DMEMWrite),
    .IRWrite(IRWrite), .MemtoReg(MemtoReg), .PCSource(PCSource),
    .ALUSel(ALUSel), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .RegWrite(RegWrite), .RegReadSel(RegReadSel)
  );

  typedef struct packed {
    logic       pcw, pcwc, dmw, irw;
    logic [1:0] m2r, pcsrc;
    logic [3:0] alusel;
    logic       srca;
    logic [1:0] srcb;
    logic       regw, rrs;
  } outs_t;

  outs_t act;
  assign act = {PCWrite, PCWriteCond, DMEMWrite, IRWrite, MemtoReg, PCSource,
                ALUSel, ALUSrcA, ALUSrcB, RegWrite, RegReadSel};

  outs_t exp_q[$];
  outs_t trace[$];
  int    checks = 0;
  int    errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Model: each instruction is fetch + decode, then up to two class-specific cycles.
  function automatic int push_model(input logic [5:0] op);
    outs_t f, d, e, w;
    int    n;
    f = '0; f.irw = 1'b1; f.pcw = 1'b1; f.srcb = 2'b01; f.alusel = 4'd2;
    d = '0; d.srcb = 2'b10; d.alusel = 4'd2;
    e = '0; w = '0; n = 4;
    if (op[5:3] == 3'b010) begin
      e.srca = 1'b1; e.srcb = 2'b00; e.alusel = {1'b0, op[2:0]};
      w.regw = 1'b1; w.m2r = 2'b00;
    end else if (op == 6'b110010 || op == 6'b110011 || op == 6'b110111) begin
      e.srca = 1'b1; e.srcb = 2'b10; e.alusel = {1'b0, op[2:0]};
      w.regw = 1'b1; w.m2r = 2'b00;
    end else if (op == 6'b110100 || op == 6'b110101 || op == 6'b110110) begin
      e.srca = 1'b1; e.srcb = 2'b11; e.alusel = {1'b0, op[2:0]};
      w.regw = 1'b1; w.m2r = 2'b00;
    end else if (op == 6'b111011) begin
      e.srca = 1'b1; e.srcb = 2'b10; e.alusel = 4'd2;
      w.regw = 1'b1; w.m2r = 2'b01;
    end else if (op == 6'b000001 || op == 6'b100000 || op == 6'b111001 ||
                 op == 6'b111010 || op == 6'b111100) begin
      e.rrs = 1'b1;
      case (op)
        6'b000001: begin w.pcw = 1'b1; w.pcsrc = 2'b10; end
        6'b100000: begin
          w.rrs = 1'b1; w.srca = 1'b1; w.alusel = 4'd3; w.pcwc = 1'b1; w.pcsrc = 2'b01;
        end
        6'b111001: begin w.regw = 1'b1; w.m2r = 2'b10; end
        6'b111010: begin w.regw = 1'b1; w.m2r = 2'b11; end
        default:   begin w.rrs = 1'b1; w.srca = 1'b1; w.srcb = 2'b10; w.alusel = 4'd2; w.dmw = 1'b1; end
      endcase
    end else begin
      n = 2;
    end
    exp_q.push_back(f);
    exp_q.push_back(d);
    if (n == 4) begin
      exp_q.push_back(e);
      exp_q.push_back(w);
    end
    return n;
  endfunction

  // Compare process: one model vector per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset && exp_q.size() > 0) check("cycle outputs", act, exp_q.pop_front());
  end

  // Called at posedge+1 with the DUT in S0; returns after the instruction retires.
  task automatic run_instr(input logic [5:0] op, output int len);
    len = push_model(op);
    opcode = op;
    trace.delete();
    for (int i = 0; i < len; i++) begin
      trace.push_back(act);
      @(posedge clk); #1;
    end
  endtask

  int len;

  initial begin
    reset  = 1'b0;
    opcode = 6'b000000;
    repeat (4) @(negedge clk);
    check("rst IRWrite", IRWrite, 1);
    check("rst PCWrite", PCWrite, 1);
    check("rst ALUSrcB", ALUSrcB, 2'b01);
    check("rst ALUSel", ALUSel, 4'b0010);
    check("rst others", {PCWriteCond, DMEMWrite, MemtoReg, PCSource, ALUSrcA, RegWrite, RegReadSel}, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    run_instr(6'b010011, len);            // SUB
    check("SUB len", len, 4);
    check("SUB S1 IRWrite", trace[1].irw, 0);
    check("SUB S2 ALUSel", trace[2].alusel, 4'b0011);
    check("SUB S2 ALUSrcA", trace[2].srca, 1);
    check("SUB S2 ALUSrcB", trace[2].srcb, 2'b00);
    check("SUB S6 RegWrite", trace[3].regw, 1);
    check("SUB S6 MemtoReg", trace[3].m2r, 2'b00);

    run_instr(6'b110010, len);            // ADDI
    check("ADDI ALUSrcB", trace[2].srcb, 2'b10);
    check("ADDI ALUSel", trace[2].alusel, 4'b0010);
    run_instr(6'b110100, len);            // ORI
    check("ORI ALUSrcB", trace[2].srcb, 2'b11);
    check("ORI ALUSel", trace[2].alusel, 4'b0100);
    run_instr(6'b110111, len);            // SLTI
    check("SLTI ALUSrcB", trace[2].srcb, 2'b10);
    check("SLTI ALUSel", trace[2].alusel, 4'b0111);

    run_instr(6'b000001, len);            // J
    check("J S14 RegReadSel", trace[2].rrs, 1);
    check("J S12 PCWrite", trace[3].pcw, 1);
    check("J S12 PCSource", trace[3].pcsrc, 2'b10);
    run_instr(6'b100000, len);            // BEQ
    check("BEQ PCWriteCond", trace[3].pcwc, 1);
    check("BEQ PCSource", trace[3].pcsrc, 2'b01);
    check("BEQ ALUSel", trace[3].alusel, 4'b0011);

    run_instr(6'b111001, len);            // LI
    check("LI MemtoReg", trace[3].m2r, 2'b10);
    check("LI RegWrite", trace[3].regw, 1);
    run_instr(6'b111010, len);            // LUI
    check("LUI MemtoReg", trace[3].m2r, 2'b11);
    run_instr(6'b111011, len);            // LWI
    check("LWI S5 ALUSrcB", trace[2].srcb, 2'b10);
    check("LWI S7 MemtoReg", trace[3].m2r, 2'b01);
    run_instr(6'b111100, len);            // SWI
    check("SWI DMEMWrite", trace[3].dmw, 1);
    check("SWI RegWrite", trace[3].regw, 0);

    run_instr(6'b000000, len);            // NOP
    check("NOP len", len, 2);
    run_instr(6'b111111, len);            // undefined
    check("undef len", len, 2);
    run_instr(6'b100001, len);            // undefined, near BEQ
    run_instr(6'b110110, len);            // XORI
    run_instr(6'b010000, len);            // MOV
    check("MOV ALUSel", trace[2].alusel, 4'b0000);

    // Abort an ADD in its execute cycle with an asynchronous reset.
    void'(push_model(6'b010010));
    opcode = 6'b010010;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("ADD S2 ALUSrcA", ALUSrcA, 1);
    #2;
    exp_q.delete();
    reset = 1'b0;
    #1;
    check("abort IRWrite", IRWrite, 1);
    check("abort ALUSrcA", ALUSrcA, 0);
    check("abort ALUSrcB", ALUSrcB, 2'b01);
    @(posedge clk); #1;
    check("held PCWrite", PCWrite, 1);
    reset = 1'b1;

    run_instr(6'b110011, len);            // SUBI after reset
    check("SUBI ALUSel", trace[2].alusel, 4'b0011);
    run_instr(6'b000000, len);
    check("queue drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
